bank_group_arbiter: RTL and testbench

BANK_GROUP_ARBITER -- requirements
Module: bank_group_arbiter

---
 rtl/mc_backend_pkg.sv | 21 ++
 rtl/bank_group_arbiter_rr_pick.sv | 31 +++
 rtl/bank_group_arbiter.sv | 159 +++++++++++++++
 tb/tb_bank_group_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_backend_pkg.sv
// Shared definitions for the memory-controller back-end arbiters:
// FSM state type, parameter defaults and internal counter widths.
package mc_backend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_GROUPS = 4;
   localparam int DEF_MAX_BURST  = 4;
   localparam int DEF_SWITCH_GAP = 1;
   localparam int DEF_TIMEOUT    = 16;

   // Sized for the largest legal MAX_BURST, TIMEOUT and SWITCH_GAP.
   localparam int BURST_W = 4;
   localparam int TOUT_W  = 8;
   localparam int GAP_W   = 3;

endpackage

// File: rtl/bank_group_arbiter_rr_pick.sv
// Round-robin search: first requesting index found upward from last+1,
// wrapping around, with last itself considered at the very end.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          any,
   output logic [IW-1:0] idx
);

   // Walk from the farthest offset down to the nearest so the nearest hit wins.
   always_comb begin
      int cand;
      any  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int off = N; off >= 1; off--) begin
         cand = int'(last) + off;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (req[cand[IW-1:0]]) begin
            any = 1'b1;
            idx = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/bank_group_arbiter.sv
// Bank-group arbiter: round-robin grant with burst limit, switch gap
// and ACTIVE-state timeout.
module bank_group_arbiter
   import mc_backend_pkg::*;
#(
   parameter int NUM_GROUPS = DEF_NUM_GROUPS,
   parameter int MAX_BURST  = DEF_MAX_BURST,
   parameter int SWITCH_GAP = DEF_SWITCH_GAP,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_GROUPS-1:0]         req,
   input  logic [NUM_GROUPS-1:0]         done,
   output logic [NUM_GROUPS-1:0]         start,
   output logic [$clog2(NUM_GROUPS)-1:0] sel,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int SW = $clog2(NUM_GROUPS);

   arb_state_t            r_state, w_state_next;
   logic [NUM_GROUPS-1:0] r_start, w_start_next;
   logic [SW-1:0]         r_sel,   w_sel_next;
   logic [SW-1:0]         r_last,  w_last_next;
   logic [BURST_W-1:0]    r_burst, w_burst_next;
   logic [TOUT_W-1:0]     r_tcnt,  w_tcnt_next;
   logic [GAP_W-1:0]      r_gap,   w_gap_next;
   logic                  r_terr,  w_terr_next;

   logic          w_any;
   logic [SW-1:0] w_idx;
   logic          w_done_sel;
   logic          w_req_sel;
   logic          w_others;
   logic          w_keep;
   logic          w_tout;
   logic          w_leave;
   logic          w_leave_busy;
   logic          w_grant;

   rr_pick #(
      .N  (NUM_GROUPS),
      .IW (SW)
   ) u_rr_pick (
      .req  (req),
      .last (r_last),
      .any  (w_any),
      .idx  (w_idx)
   );

   // r_start is one-hot at r_sel while ACTIVE, so masking with it isolates the other groups.
   assign w_done_sel   = done[r_sel];
   assign w_req_sel    = req[r_sel];
   assign w_others     = |(req & ~r_start);
   assign w_keep       = w_done_sel && w_req_sel &&
                         ((r_burst < BURST_W'(MAX_BURST)) || !w_others);
   assign w_tout       = !w_done_sel && (r_tcnt == TOUT_W'(TIMEOUT - 1));
   assign w_leave      = (w_done_sel && !w_keep) || w_tout;
   // After a timeout the owner itself may still be waiting, so any request counts.
   assign w_leave_busy = w_tout ? (|req) : w_others;

   always_comb begin
      w_state_next = r_state;
      w_start_next = r_start;
      w_sel_next   = r_sel;
      w_last_next  = r_last;
      w_burst_next = r_burst;
      w_tcnt_next  = r_tcnt;
      w_gap_next   = r_gap;
      w_terr_next  = 1'b0;
      w_grant      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_grant = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (w_keep) begin
               if (r_burst < BURST_W'(MAX_BURST)) begin
                  w_burst_next = r_burst + 1'b1;
               end
               w_tcnt_next = '0;
            end else if (w_leave) begin
               w_terr_next  = w_tout;
               w_start_next = '0;
               w_burst_next = '0;
               w_tcnt_next  = '0;
               if (!w_leave_busy) begin
                  w_state_next = ST_IDLE;
               end else if (SWITCH_GAP > 0) begin
                  w_state_next = ST_GAP;
                  w_gap_next   = GAP_W'(SWITCH_GAP - 1);
               end else begin
                  w_grant = 1'b1;
               end
            end else begin
               w_tcnt_next = r_tcnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (r_gap == '0) begin
               if (w_any) begin
                  w_grant = 1'b1;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end else begin
               w_gap_next = r_gap - 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_start_next = '0;
         end
      endcase

      if (w_grant) begin
         w_state_next        = ST_ACTIVE;
         w_start_next        = '0;
         w_start_next[w_idx] = 1'b1;
         w_sel_next          = w_idx;
         w_last_next         = w_idx;
         w_burst_next        = BURST_W'(1);
         w_tcnt_next         = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_start <= '0;
         r_sel   <= '0;
         r_last  <= SW'(NUM_GROUPS - 1);
         r_burst <= '0;
         r_tcnt  <= '0;
         r_gap   <= '0;
         r_terr  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_start <= w_start_next;
         r_sel   <= w_sel_next;
         r_last  <= w_last_next;
         r_burst <= w_burst_next;
         r_tcnt  <= w_tcnt_next;
         r_gap   <= w_gap_next;
         r_terr  <= w_terr_next;
      end
   end

   assign start       = r_start;
   assign sel         = r_sel;
   assign busy        = |r_start;
   assign timeout_err = r_terr;

endmodule

// File: tb/tb_bank_group_arbiter.sv
// Bench for bank_group_arbiter: vector table, burst/timeout sequences
// and randomized traffic against an ownership-based reference model.
module tb_bank_group_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;
   localparam int SG = 1;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] start;
   logic [1:0] sel;
   logic       busy;
   logic       terr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bank_group_arbiter #(
      .NUM_GROUPS (N),
      .MAX_BURST  (MB),
      .SWITCH_GAP (SG),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .start       (start),
      .sel         (sel),
      .busy        (busy),
      .timeout_err (terr)
   );

   // Reference model: who owns the grant, how long, and how much gap remains.
   int m_owner = -1;
   int m_last  = N - 1;
   int m_burst = 0;
   int m_age   = 0;
   int m_gap   = 0;
   bit m_terr  = 1'b0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] exp_start;
      logic       exp_terr;
   } vec_t;

   vec_t vecs[$];

   function automatic int first_one(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   task automatic model_pick();
      for (int off = 1; off <= N; off++) begin
         int g;
         g = (m_last + off) % N;
         if (req[g]) begin
            m_owner = g;
            m_last  = g;
            m_burst = 1;
            m_age   = 0;
            return;
         end
      end
   endtask

   task automatic model_release(input bit more);
      m_owner = -1;
      m_burst = 0;
      m_age   = 0;
      if (more) begin
         if (SG > 0) m_gap = SG;
         else model_pick();
      end
   endtask

   task automatic model_update();
      m_terr = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_last  = N - 1;
         m_burst = 0;
         m_age   = 0;
         m_gap   = 0;
      end else if (m_owner >= 0) begin
         bit others;
         others = (req & ~(4'b0001 << m_owner)) != 4'b0000;
         if (done[m_owner]) begin
            if (req[m_owner] && (m_burst < MB || !others)) begin
               if (m_burst < MB) m_burst++;
               m_age = 0;
            end else begin
               model_release(others);
            end
         end else if (m_age + 1 >= TO) begin
            m_terr = 1'b1;
            model_release(req != 4'b0000);
         end else begin
            m_age++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) model_pick();
      end else begin
         model_pick();
      end
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic r, input logic [3:0] q, input logic [3:0] d);
      rst  = r;
      req  = q;
      done = d;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [3:0] es, input logic et);
      check({name, ".start"}, 32'(start), 32'(es));
      check({name, ".busy"}, 32'(busy), 32'(|es));
      check({name, ".timeout_err"}, 32'(terr), 32'(et));
      if (es != 4'b0000) begin
         check({name, ".sel"}, 32'(sel), 32'(first_one(es)));
      end
   endtask

   task automatic add_vec(input logic r, input logic [3:0] q, input logic [3:0] d,
                          input logic [3:0] es, input logic et);
      vec_t v;
      v.rst       = r;
      v.req       = q;
      v.done      = d;
      v.exp_start = es;
      v.exp_terr  = et;
      vecs.push_back(v);
   endtask

   initial begin
      logic [3:0] oh;
      logic [3:0] exp_s;
      int         mode;

      apply(1'b1, 4'b0000, 4'b0000);

      // Two candidates: group 0 first, one gap cycle, then group 2; foreign done ignored.
      add_vec(1, 4'b0000, 4'b0000, 4'b0000, 0);
      add_vec(0, 4'b0101, 4'b0000, 4'b0001, 0);
      add_vec(0, 4'b0100, 4'b0001, 4'b0000, 0);
      add_vec(0, 4'b0100, 4'b0000, 4'b0100, 0);
      add_vec(0, 4'b0100, 4'b0001, 4'b0100, 0);
      add_vec(0, 4'b0000, 4'b0100, 4'b0000, 0);
      add_vec(0, 4'b0000, 4'b0000, 4'b0000, 0);
      // Lone requester keeps the grant across dones, burst count saturates.
      add_vec(1, 4'b0000, 4'b0000, 4'b0000, 0);
      add_vec(0, 4'b0001, 4'b0000, 4'b0001, 0);
      add_vec(0, 4'b0001, 4'b0001, 4'b0001, 0);
      add_vec(0, 4'b0001, 4'b0100, 4'b0001, 0);
      add_vec(0, 4'b0001, 4'b0001, 4'b0001, 0);
      add_vec(0, 4'b0001, 4'b0001, 4'b0001, 0);
      add_vec(0, 4'b0001, 4'b0001, 4'b0001, 0);
      add_vec(0, 4'b0000, 4'b0001, 4'b0000, 0);
      // Reset mid-grant, then priority order after reset.
      add_vec(1, 4'b0000, 4'b0000, 4'b0000, 0);
      add_vec(0, 4'b0010, 4'b0000, 4'b0010, 0);
      add_vec(1, 4'b0010, 4'b0000, 4'b0000, 0);
      add_vec(0, 4'b0010, 4'b0000, 4'b0010, 0);
      add_vec(1, 4'b1111, 4'b0000, 4'b0000, 0);
      add_vec(0, 4'b1111, 4'b0000, 4'b0001, 0);
      add_vec(0, 4'b1111, 4'b0001, 4'b0001, 0);
      add_vec(0, 4'b1110, 4'b0001, 4'b0000, 0);
      add_vec(0, 4'b1110, 4'b0000, 4'b0010, 0);
      add_vec(0, 4'b0000, 4'b0010, 4'b0000, 0);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].req, vecs[i].done);
         tick();
         check_out($sformatf("vec%0d", i), vecs[i].exp_start, vecs[i].exp_terr);
      end

      // Two groups contending: four grants each, alternating, gap between.
      apply(1'b1, 4'b0000, 4'b0000);
      tick();
      apply(1'b0, 4'b0011, 4'b0000);
      tick();
      check_out("burst_first", 4'b0001, 1'b0);
      for (int k = 0; k < 16; k++) begin
         oh = 4'b0001 << ((k / 4) % 2);
         check_out($sformatf("burst%0d_pre", k), oh, 1'b0);
         apply(1'b0, 4'b0011, oh);
         tick();
         apply(1'b0, 4'b0011, 4'b0000);
         if (k % 4 == 3) begin
            check_out($sformatf("burst%0d_gap", k), 4'b0000, 1'b0);
            tick();
         end
      end
      check_out("burst_end", 4'b0001, 1'b0);

      // Timeout on a lone requester, re-grant, then done beating the timeout.
      apply(1'b1, 4'b0000, 4'b0000);
      tick();
      apply(1'b0, 4'b1000, 4'b0000);
      tick();
      check_out("to_grant", 4'b1000, 1'b0);
      for (int i = 1; i < TO; i++) begin
         tick();
         check_out($sformatf("to_hold%0d", i), 4'b1000, 1'b0);
      end
      tick();
      check_out("to_abort", 4'b0000, 1'b1);
      tick();
      check_out("to_regrant", 4'b1000, 1'b0);
      for (int i = 1; i < TO; i++) begin
         tick();
      end
      apply(1'b0, 4'b1000, 4'b1000);
      tick();
      check_out("to_done_wins", 4'b1000, 1'b0);
      apply(1'b0, 4'b1000, 4'b0000);
      for (int i = 1; i < TO; i++) begin
         tick();
         check_out($sformatf("to_rehold%0d", i), 4'b1000, 1'b0);
      end
      tick();
      check_out("to_abort2", 4'b0000, 1'b1);

      // Randomized traffic against the reference model.
      apply(1'b1, 4'b0000, 4'b0000);
      tick();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         mode = (cyc / 250) % 4;
         rst  = ($urandom % 400) == 0;
         req  = 4'($urandom);
         if (mode == 0) req = req & 4'($urandom);
         case (mode)
            0, 1:    done = 4'($urandom);
            2:       done = (($urandom % 8) == 0) ? 4'($urandom) : 4'b0000;
            default: done = (($urandom % 40) == 0) ? 4'b1111 : 4'b0000;
         endcase
         tick();
         exp_s = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         check_out($sformatf("rnd%0d", cyc), exp_s, m_terr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
